// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares a single memory/L2 line port between the I-cache and D-cache miss
// paths. One line transfer is in flight at a time. The winning request is
// latched in IDLE, driven to memory until mem_resp, and the returned line is
// handed back to the granted requester with a one-cycle resp pulse. Every
// output is a register.
//
// Compile-time option:
//   ARB_ROUND_ROBIN_EN  defined   : a conflict goes to the side not granted last
//                       undefined : the D-cache always wins a conflict
//
// Handshake: a requester raises read/write with a stable address and data and
// holds them until its resp pulse. It may drop the request in the resp
// (DONE) cycle. mem_read/mem_write stay high with stable mem_addr and
// mem_wdata until the edge that samples mem_resp=1.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   i_read, i_addr           I-cache line read request
//   i_resp, i_rdata          I-cache completion pulse and returned line
//   d_read, d_write, d_addr  D-cache line request (write wins if both high)
//   d_wdata                  D-cache write-back line
//   d_resp, d_rdata          D-cache completion pulse and returned line
//   mem_read, mem_write      memory strobes
//   mem_addr, mem_wdata      latched address and write line
//   mem_resp, mem_rdata      memory completion and read line
//   busy                     high whenever the FSM is not in IDLE
//   gnt_d                    current/last grant (1 = D-cache, 0 = I-cache)
//   dbg_state                encoded FSM state (0 IDLE, 1 I_XFER, 2 D_XFER, 3 DONE)

module mem_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_resp,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [LINE_W-1:0] d_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_resp,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              busy,
    output logic              gnt_d,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_XFER = 2'd1,
        D_XFER = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic                lat_write, lat_write_nxt;
    logic                gnt_d_nxt;
    logic [ADDR_W-1:0]   mem_addr_nxt;
    logic [LINE_W-1:0]   mem_wdata_nxt;
    logic                mem_read_nxt, mem_write_nxt;
    logic                i_resp_nxt, d_resp_nxt;
    logic [LINE_W-1:0]   i_rdata_nxt, d_rdata_nxt;
    logic                busy_nxt;

    logic                d_req;
    logic                d_wins_conflict;
    logic                grant_d;

    // A simultaneous read+write from the D-cache is treated as a write.
    assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
    // Alternate on conflicts; gnt_d resets to 0 so the first conflict goes to D.
    assign d_wins_conflict = ~gnt_d;
`else
    // D misses stall the whole pipeline, so D always wins; I may starve.
    assign d_wins_conflict = 1'b1;
`endif

    assign grant_d = d_req & (~i_read | d_wins_conflict);

    assign dbg_state = state;

    always_comb begin
        state_nxt     = state;
        lat_write_nxt = lat_write;
        gnt_d_nxt     = gnt_d;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        mem_read_nxt  = 1'b0;
        mem_write_nxt = 1'b0;
        i_resp_nxt    = 1'b0;
        d_resp_nxt    = 1'b0;
        i_rdata_nxt   = i_rdata;
        d_rdata_nxt   = d_rdata;

        case (state)
            IDLE: begin
                if (d_req || i_read) begin
                    gnt_d_nxt = grant_d;
                    if (grant_d) begin
                        lat_write_nxt = d_write;
                        mem_addr_nxt  = d_addr;
                        mem_wdata_nxt = d_wdata;
                        mem_read_nxt  = ~d_write;
                        mem_write_nxt = d_write;
                        state_nxt     = D_XFER;
                    end else begin
                        // The I-cache never writes; clear the write line.
                        lat_write_nxt = 1'b0;
                        mem_addr_nxt  = i_addr;
                        mem_wdata_nxt = '0;
                        mem_read_nxt  = 1'b1;
                        state_nxt     = I_XFER;
                    end
                end
            end

            I_XFER, D_XFER: begin
                // Requester inputs are ignored here; the latched copy rules.
                if (mem_resp) begin
                    state_nxt = DONE;
                    if (gnt_d) begin
                        d_resp_nxt  = 1'b1;
                        d_rdata_nxt = mem_rdata;
                    end else begin
                        i_resp_nxt  = 1'b1;
                        i_rdata_nxt = mem_rdata;
                    end
                end else begin
                    mem_read_nxt  = ~lat_write;
                    mem_write_nxt = lat_write;
                end
            end

            DONE: begin
                // One dead edge lets the requester drop its request.
                state_nxt = IDLE;
            end

            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lat_write <= 1'b0;
            gnt_d     <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            i_resp    <= 1'b0;
            d_resp    <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            lat_write <= lat_write_nxt;
            gnt_d     <= gnt_d_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            mem_read  <= mem_read_nxt;
            mem_write <= mem_write_nxt;
            i_resp    <= i_resp_nxt;
            d_resp    <= d_resp_nxt;
            i_rdata   <= i_rdata_nxt;
            d_rdata   <= d_rdata_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int ADDR_W = 16;
    localparam int LINE_W = 128;

    logic              clk;
    logic              rst;
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic              i_resp;
    logic [LINE_W-1:0] i_rdata;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic              d_resp;
    logic [LINE_W-1:0] d_rdata;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic              mem_resp;
    logic [LINE_W-1:0] mem_rdata;
    logic              busy;
    logic              gnt_d;
    logic [1:0]        dbg_state;

    int total;
    int bad;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_read    (i_read),
        .i_addr    (i_addr),
        .i_resp    (i_resp),
        .i_rdata   (i_rdata),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_resp    (d_resp),
        .d_rdata   (d_rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_resp  (mem_resp),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .gnt_d     (gnt_d),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled at negedge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        i_read    = 1'b0;
        i_addr    = '0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_resp  = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        total++;
        if ({i_resp, d_resp, mem_read, mem_write, busy, gnt_d} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=000000",
                     {i_resp, d_resp, mem_read, mem_write, busy, gnt_d});
        end
        total++;
        if (mem_addr !== 16'h0 || mem_wdata !== 128'h0 || i_rdata !== 128'h0 || d_rdata !== 128'h0) begin
            bad++;
            $display("FAIL reset_data got addr=%h wdata=%h irdata=%h drdata=%h want all zero",
                     mem_addr, mem_wdata, i_rdata, d_rdata);
        end
        total++;
        if (dbg_state !== 2'd0) begin
            bad++;
            $display("FAIL reset_state got=%0d want=0", dbg_state);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_i_read();
        logic [LINE_W-1:0] line;
        line   = {16{8'hA5}};
        i_read = 1'b1;               // cycle 0
        i_addr = 16'h1230;
        step();                      // cycle 1
        total++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 16'h1230) begin
            bad++;
            $display("FAIL i_strobe got rd=%b wr=%b addr=%h want rd=1 wr=0 addr=1230",
                     mem_read, mem_write, mem_addr);
        end
        total++;
        if (busy !== 1'b1 || gnt_d !== 1'b0 || dbg_state !== 2'd1) begin
            bad++;
            $display("FAIL i_grant got busy=%b gnt_d=%b state=%0d want busy=1 gnt_d=0 state=1",
                     busy, gnt_d, dbg_state);
        end
        step();                      // cycle 2
        step();                      // cycle 3
        step();                      // cycle 4
        total++;
        if (mem_read !== 1'b1 || mem_addr !== 16'h1230 || i_resp !== 1'b0) begin
            bad++;
            $display("FAIL i_hold got rd=%b addr=%h i_resp=%b want rd=1 addr=1230 i_resp=0",
                     mem_read, mem_addr, i_resp);
        end
        mem_resp  = 1'b1;
        mem_rdata = line;
        step();                      // cycle 5
        total++;
        if (i_resp !== 1'b1 || i_rdata !== line || d_resp !== 1'b0 || mem_read !== 1'b0) begin
            bad++;
            $display("FAIL i_resp got i_resp=%b i_rdata=%h d_resp=%b rd=%b want 1 %h 0 0",
                     i_resp, i_rdata, d_resp, mem_read, line);
        end
        mem_resp  = 1'b0;
        mem_rdata = '0;
        i_read    = 1'b0;
        step();                      // cycle 6
        total++;
        if (i_resp !== 1'b0 || busy !== 1'b0 || i_rdata !== line) begin
            bad++;
            $display("FAIL i_after got i_resp=%b busy=%b i_rdata=%h want 0 0 %h",
                     i_resp, busy, i_rdata, line);
        end
    endtask

    task automatic test_d_write();
        logic [LINE_W-1:0] wline;
        wline   = 128'h0123456789ABCDEF0123456789ABCDEF;
        d_write = 1'b1;              // cycle 0
        d_addr  = 16'h4440;
        d_wdata = wline;
        step();                      // cycle 1
        total++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 16'h4440 || mem_wdata !== wline) begin
            bad++;
            $display("FAIL d_wr_strobe got wr=%b rd=%b addr=%h wdata=%h want 1 0 4440 %h",
                     mem_write, mem_read, mem_addr, mem_wdata, wline);
        end
        total++;
        if (gnt_d !== 1'b1 || dbg_state !== 2'd2) begin
            bad++;
            $display("FAIL d_wr_grant got gnt_d=%b state=%0d want 1 2", gnt_d, dbg_state);
        end
        mem_resp = 1'b1;
        step();                      // cycle 2
        total++;
        if (d_resp !== 1'b1 || i_resp !== 1'b0 || mem_write !== 1'b0) begin
            bad++;
            $display("FAIL d_wr_resp got d_resp=%b i_resp=%b wr=%b want 1 0 0",
                     d_resp, i_resp, mem_write);
        end
        mem_resp = 1'b0;
        d_write  = 1'b0;
        step();                      // cycle 3
        total++;
        if (busy !== 1'b0 || d_resp !== 1'b0) begin
            bad++;
            $display("FAIL d_wr_done got busy=%b d_resp=%b want 0 0", busy, d_resp);
        end
    endtask

    task automatic test_conflict();
        logic [LINE_W-1:0] exp_q[$];   // expected grant order, 1 = D
        logic [LINE_W-1:0] got;
        int dcnt;
        int icnt;
        int cyc;
`ifdef ARB_ROUND_ROBIN_EN
        exp_q = '{1, 0, 1, 0, 1, 0};
`else
        exp_q = '{1, 1, 1, 0, 0, 0};
`endif
        dcnt   = 0;
        icnt   = 0;
        cyc    = 0;
        i_read = 1'b1;
        i_addr = 16'h2000;
        d_read = 1'b1;
        d_addr = 16'h3000;
        while (!(dcnt == 3 && icnt == 3 && busy === 1'b0) && cyc < 200) begin
            if (d_resp === 1'b1 || i_resp === 1'b1) begin
                got = (d_resp === 1'b1) ? 128'd1 : 128'd0;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL conflict_extra got grant=%0d want none", got);
                end else begin
                    if (got !== exp_q[0]) begin
                        bad++;
                        $display("FAIL conflict_order n=%0d got=%0d want=%0d",
                                 dcnt + icnt, got, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                if (d_resp === 1'b1) begin
                    dcnt++;
                    if (dcnt == 3) d_read = 1'b0;
                end
                if (i_resp === 1'b1) begin
                    icnt++;
                    if (icnt == 3) i_read = 1'b0;
                end
            end
            mem_resp  = mem_read | mem_write;
            mem_rdata = {8{16'(cyc)}};
            step();
            cyc++;
        end
        mem_resp = 1'b0;
        i_read   = 1'b0;
        d_read   = 1'b0;
        total++;
        if (cyc >= 200 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL conflict_timeout got remaining=%0d cycles=%0d want remaining=0",
                     exp_q.size(), cyc);
        end
    endtask

    task automatic test_addr_toggle();
        logic [LINE_W-1:0] line;
        line   = 128'hDEADBEEF_00000000_CAFEF00D_11112222;
        d_read = 1'b1;               // cycle 0
        d_addr = 16'h0010;
        step();                      // cycle 1
        total++;
        if (mem_addr !== 16'h0010 || mem_read !== 1'b1) begin
            bad++;
            $display("FAIL toggle_start got addr=%h rd=%b want 0010 1", mem_addr, mem_read);
        end
        d_addr = 16'h0020;
        step();                      // cycle 2
        total++;
        if (mem_addr !== 16'h0010) begin
            bad++;
            $display("FAIL toggle_hold got addr=%h want 0010", mem_addr);
        end
        mem_resp  = 1'b1;
        mem_rdata = line;
        step();                      // cycle 3
        total++;
        if (d_resp !== 1'b1 || i_resp !== 1'b0 || d_rdata !== line) begin
            bad++;
            $display("FAIL toggle_resp got d_resp=%b i_resp=%b d_rdata=%h want 1 0 %h",
                     d_resp, i_resp, d_rdata, line);
        end
        mem_resp = 1'b0;
        d_read   = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_xfer();
        logic [LINE_W-1:0] line;
        line   = 128'h00FF00FF_00FF00FF_00FF00FF_00FF00FF;
        i_read = 1'b1;               // cycle 0
        i_addr = 16'h5550;
        step();                      // cycle 1 (granted)
        step();                      // cycle 2
        rst = 1'b1;
        #1;
        total++;
        if (mem_read !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0) begin
            bad++;
            $display("FAIL rst_async got rd=%b busy=%b state=%0d want 0 0 0",
                     mem_read, busy, dbg_state);
        end
        i_read   = 1'b0;
        mem_resp = 1'b1;             // late response must be ignored
        step();
        rst      = 1'b0;
        mem_resp = 1'b0;
        step();
        total++;
        if (i_resp !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_no_resp got i_resp=%b busy=%b want 0 0", i_resp, busy);
        end
        i_read = 1'b1;               // re-request, cycle 0
        i_addr = 16'h5550;
        step();                      // cycle 1
        total++;
        if (mem_read !== 1'b1 || mem_addr !== 16'h5550) begin
            bad++;
            $display("FAIL rst_rereq got rd=%b addr=%h want 1 5550", mem_read, mem_addr);
        end
        mem_resp  = 1'b1;
        mem_rdata = line;
        step();                      // cycle 2
        total++;
        if (i_resp !== 1'b1 || i_rdata !== line) begin
            bad++;
            $display("FAIL rst_reresp got i_resp=%b i_rdata=%h want 1 %h", i_resp, i_rdata, line);
        end
        mem_resp = 1'b0;
        i_read   = 1'b0;
        step();
    endtask

    task automatic test_spurious_mem_resp();
        idle_inputs();
        mem_resp = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (i_resp !== 1'b0 || d_resp !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0) begin
                bad++;
                $display("FAIL spurious k=%0d got i_resp=%b d_resp=%b busy=%b state=%0d want 0 0 0 0",
                         k, i_resp, d_resp, busy, dbg_state);
            end
        end
        mem_resp = 1'b0;
        step();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_single_i_read();
        test_d_write();
        test_conflict();
        test_addr_toggle();
        test_reset_mid_xfer();
        test_spurious_mem_resp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
